if_id_inst_queue: RTL and testbench
===================================

# if_id_inst_queue

Dual-issue instruction queue between the fetch stage and the decode/rename stage. Accepts up to two instructions per cycle in the `IF_ID_Port` form (Inst1/Inst1_en, Inst2/Inst2_en, PC), buffers them in program order, and presents the two oldest entries to decode each cycle. It decouples fetch from decode stalls and discards all contents on a pipeline flush.

## Interface
- `DEPTH`, default 8: entry count; a power of 2, at least 4.
- `Clk` input 1: system clock, rising edge.
- `Rst` input 1: asynchronous, active-high reset.
- `Flush` input 1: synchronous flush, for example on a branch mispredict.
- `Stall` input 1: decode cannot accept this cycle.
- `In_Inst1` input 32: older fetched instruction.
- `In_Inst1_en` input 1: `In_Inst1` valid.
- `In_Inst2` input 32: younger fetched instruction.
- `In_Inst2_en` input 1: `In_Inst2` valid.
- `In_PC` input 32: PC of `In_Inst1`. The PC of `In_Inst2` is `In_PC+4`.
- `In_ready` output 1: at least 2 free entries exist; fetch may present a bundle.
- `Out_Inst1` / `Out_PC1` / `Out_Inst1_en` output 32/32/1: oldest entry.
- `Out_Inst2` / `Out_PC2` / `Out_Inst2_en` output 32/32/1: second-oldest entry.
- `Count` output $clog2(DEPTH+1): current occupancy.

## Operation
- **Storage:** circular buffer of {inst[31:0], pc[31:0]} with head and tail pointers of `$clog2(DEPTH)` bits that wrap modulo DEPTH, plus a `Count` register.
- **Enqueue:** qualified only when `In_ready`=1.
  - Valid inputs are written at tail in order, with compaction.
  - Both valid: 2 entries, PCs `In_PC` and `In_PC+4`.
  - Only `In_Inst1_en`: 1 entry at `In_PC`.
  - Only `In_Inst2_en`: 1 entry at `In_PC+4`.
  - Enables with `In_ready`=0 are ignored and nothing is written. Fetch must hold its bundle.
- **Output:** combinational from head.
  - `Out_Inst1_en` = (Count≥1).
  - `Out_Inst2_en` = (Count≥2).
  - When an enable is 0, the matching data and PC outputs are 0.
- **Dequeue:** when `Stall`=0, pop `Out_Inst1_en` + `Out_Inst2_en` entries. When `Stall`=1, pop nothing.
- **Simultaneous enqueue and dequeue:** `Count_next` = Count + enq − deq. Enqueue never overwrites unpopped data because `In_ready` guarantees 2 free slots.
- **Ready:** `In_ready` = (DEPTH − Count ≥ 2). It is computed from the registered `Count`, so it is conservative: it does not account for a same-cycle dequeue.
- **Flush:** head, tail and `Count` are cleared to 0.
  - Flush has priority over enqueue and dequeue in the same cycle.
  - A bundle presented during the flush cycle is dropped.
  - Stored data is not cleared.

## Timing
- **Reset values:** `Rst`=1 asynchronously clears head, tail and `Count`. All outputs then read 0 except `In_ready`=1. The storage array is not reset.
- **Latency:** an instruction enqueued at edge N is visible on `Out_*` during cycle N+1 (1 cycle through an empty queue).
- **Full:** at Count=DEPTH−1 or DEPTH, `In_ready`=0.
- **Empty:** at Count=0, both `Out_*_en`=0 and any dequeue is a no-op. At Count=1, only slot 1 is valid.
- **Wrap-around:** a 2-entry write or read that crosses index DEPTH−1→0 splits across the wrap correctly.
- **Reset mid-operation:** takes effect immediately and is independent of `Clk`. The queue is empty in the first cycle after deassertion.

## Configuration
- **`IQ_BYPASS_EN` defined:**
  - Condition: Count=0, `Stall`=0, `Flush`=0 and `In_ready`=1.
  - In that cycle, valid inputs drive `Out_*` combinationally, compacted the same way, and are not written.
  - Latency is 0 in this case. `Count` stays 0.
  - No bypass occurs when Count≥1 (order is preserved) or when `Stall`=1 (inputs are written normally).
- **`IQ_BYPASS_EN` undefined:** outputs come from storage only, with a minimum latency of 1 cycle.

## Test plan
- **Reset then single bundle:**
  - Stimulus: assert `Rst`, then enqueue Inst1=0x11, Inst2=0x22, PC=0x400 with `Stall`=0.
  - Required (next cycle): Out1=0x11 @0x400, Out2=0x22 @0x404, both en=1.
  - Required (following cycle): Count=0.
  - With `IQ_BYPASS_EN`, the outputs appear in the same cycle.
- **Compaction:**
  - Stimulus: enqueue Inst2 only (0x33, PC=0x500), then Inst1 only (0x44, PC=0x600).
  - Required: Out1=0x33 @0x504, Out2=0x44 @0x600.
- **Fill under stall:**
  - Stimulus: with DEPTH=8 and `Stall`=1, enqueue 4 bundles of 2.
  - Required: after the 3rd bundle Count=6; after the 4th Count=8 and `In_ready`=0; a 5th bundle is ignored.
  - Then release `Stall`; required: FIFO order drains 2 per cycle and `In_ready` returns when Count≤6.
- **Wrap-around:**
  - Stimulus: drive tail to index 7, enqueue a pair, then dequeue.
  - Required: correct order, with entries at indices 7 and 0.
- **Flush collision:**
  - Stimulus: with Count=5, assert `Flush` while enqueuing a bundle and `Stall`=0.
  - Required: next cycle Count=0, both en=0, `In_ready`=1.
- **Asynchronous reset mid-stream:**
  - Stimulus: assert `Rst` between clock edges with Count=3.
  - Required: `Count` and both en drop to 0 immediately, before the next edge.

Source files
------------

// File: rtl/if_id_inst_queue_if.sv
// if_id_inst_queue_if: fetch-side and decode-side signals of the dual-issue
// instruction queue. The master modport is the fetch/decode environment and
// the slave modport is the queue itself.
interface if_id_inst_queue_if #(
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             Flush;
    logic             Stall;
    logic [31:0]      In_Inst1;
    logic             In_Inst1_en;
    logic [31:0]      In_Inst2;
    logic             In_Inst2_en;
    logic [31:0]      In_PC;
    logic             In_ready;
    logic [31:0]      Out_Inst1;
    logic [31:0]      Out_PC1;
    logic             Out_Inst1_en;
    logic [31:0]      Out_Inst2;
    logic [31:0]      Out_PC2;
    logic             Out_Inst2_en;
    logic [CNT_W-1:0] Count;

    modport master (
        output Flush, Stall,
        output In_Inst1, In_Inst1_en, In_Inst2, In_Inst2_en, In_PC,
        input  In_ready,
        input  Out_Inst1, Out_PC1, Out_Inst1_en,
        input  Out_Inst2, Out_PC2, Out_Inst2_en,
        input  Count
    );

    modport slave (
        input  Flush, Stall,
        input  In_Inst1, In_Inst1_en, In_Inst2, In_Inst2_en, In_PC,
        output In_ready,
        output Out_Inst1, Out_PC1, Out_Inst1_en,
        output Out_Inst2, Out_PC2, Out_Inst2_en,
        output Count
    );
endinterface

// File: rtl/if_id_inst_queue.sv
// if_id_inst_queue: dual-issue instruction queue between fetch and decode.
// Takes up to two instructions per cycle, keeps them in program order in a
// circular buffer and presents the two oldest entries to decode.
// Optional feature: define IQ_BYPASS_EN to forward a bundle straight to the
// outputs (zero latency) when the queue is empty and decode is not stalled.
module if_id_inst_queue #(
    parameter int DEPTH = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    if_id_inst_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    // Highest occupancy that still leaves room for a full two-entry bundle.
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             ready;
    logic             bypass;
    entry_t           in_first;
    entry_t           in_second;
    logic [1:0]       in_num;
    logic [1:0]       enq_num;
    logic [1:0]       deq_num;
    entry_t           slot1;
    entry_t           slot2;
    logic             slot1_en;
    logic             slot2_en;

    // Pointers wrap for free because DEPTH is a power of two.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input logic [1:0]       n);
        return p + PTR_W'(n);
    endfunction

    // Compact the incoming bundle: the first valid instruction always lands in
    // in_first, so an Inst2-only bundle still occupies a single slot.
    always_comb begin
        in_second = '{inst: q.In_Inst2, pc: q.In_PC + 32'd4};
        in_first  = '{inst: q.In_Inst1, pc: q.In_PC};
        in_num    = {1'b0, q.In_Inst1_en} + {1'b0, q.In_Inst2_en};
        if (!q.In_Inst1_en) begin
            in_first = in_second;
        end
    end

    // Ready, bypass qualification and the per-cycle push/pop amounts.
    always_comb begin
        ready = (count <= READY_MAX);
`ifdef IQ_BYPASS_EN
        bypass = (count == '0) && !q.Stall && !q.Flush && ready;
`else
        bypass = 1'b0;
`endif
        // A bypassed bundle goes straight to decode and is never stored.
        enq_num = (ready && !q.Flush && !bypass) ? in_num : 2'd0;
        if (q.Stall) begin
            deq_num = 2'd0;
        end else if (count >= CNT_W'(2)) begin
            deq_num = 2'd2;
        end else if (count != '0) begin
            deq_num = 2'd1;
        end else begin
            deq_num = 2'd0;
        end
    end

    // Present the two oldest entries; invalid slots read as all zeros.
    always_comb begin
        slot1    = mem[head];
        slot2    = mem[ptr_add(head, 2'd1)];
        slot1_en = (count != '0);
        slot2_en = (count >= CNT_W'(2));
        if (bypass) begin
            slot1    = in_first;
            slot2    = in_second;
            slot1_en = (in_num != 2'd0);
            slot2_en = (in_num == 2'd2);
        end
        q.Out_Inst1_en = slot1_en;
        q.Out_Inst1    = slot1_en ? slot1.inst : 32'd0;
        q.Out_PC1      = slot1_en ? slot1.pc   : 32'd0;
        q.Out_Inst2_en = slot2_en;
        q.Out_Inst2    = slot2_en ? slot2.inst : 32'd0;
        q.Out_PC2      = slot2_en ? slot2.pc   : 32'd0;
        q.In_ready     = ready;
        q.Count        = count;
    end

    // Head/tail/occupancy: async reset and flush both empty the queue, flush
    // taking priority over any same-cycle push or pop.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (q.Flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= ptr_add(head, deq_num);
            tail  <= ptr_add(tail, enq_num);
            count <= count + CNT_W'(enq_num) - CNT_W'(deq_num);
        end
    end

    // Entry storage: written at tail (second entry may wrap to index 0),
    // never reset or cleared since occupancy alone defines validity.
    always_ff @(posedge Clk) begin
        if (enq_num != 2'd0) begin
            mem[tail] <= in_first;
        end
        if (enq_num == 2'd2) begin
            mem[ptr_add(tail, 2'd1)] <= in_second;
        end
    end
endmodule

// File: tb/tb_if_id_inst_queue.sv
// tb_if_id_inst_queue: directed scenarios followed by random traffic for the
// dual-issue instruction queue, compared against a queue-based model.
module tb_if_id_inst_queue;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    logic clk;
    logic rst;
    int   checks;
    int   fails;
    ent_t mq[$];

    if_id_inst_queue_if #(.DEPTH(DEPTH)) bus ();

    if_id_inst_queue #(.DEPTH(DEPTH)) dut (
        .Clk (clk),
        .Rst (rst),
        .q   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit e1, input logic [31:0] i1, input bit e2,
                         input logic [31:0] i2, input logic [31:0] pc,
                         input bit stall, input bit flush);
        bus.In_Inst1_en = e1;
        bus.In_Inst1    = i1;
        bus.In_Inst2_en = e2;
        bus.In_Inst2    = i2;
        bus.In_PC       = pc;
        bus.Stall       = stall;
        bus.Flush       = flush;
    endtask

    task automatic idle(input bit stall);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, stall, 1'b0);
    endtask

    function automatic bit model_bypass();
`ifdef IQ_BYPASS_EN
        return (mq.size() == 0) && !bus.Stall && !bus.Flush;
`else
        return 1'b0;
`endif
    endfunction

    // Expected outputs for the current inputs and model contents.
    task automatic check_model(input string tag);
        ent_t view[$];
        logic [64:0] e1;
        logic [64:0] e2;
        if (model_bypass()) begin
            if (bus.In_Inst1_en) view.push_back(ent_t'({bus.In_Inst1, bus.In_PC}));
            if (bus.In_Inst2_en) view.push_back(ent_t'({bus.In_Inst2, bus.In_PC + 32'd4}));
            chk({tag, ".count"}, 65'(bus.Count), 65'd0);
        end else begin
            for (int i = 0; i < mq.size() && i < 2; i++) view.push_back(mq[i]);
            chk({tag, ".count"}, 65'(bus.Count), 65'(mq.size()));
        end
        chk({tag, ".ready"}, 65'(bus.In_ready), 65'((DEPTH - mq.size()) >= 2));
        e1 = (view.size() >= 1) ? {1'b1, view[0]} : 65'd0;
        e2 = (view.size() >= 2) ? {1'b1, view[1]} : 65'd0;
        chk({tag, ".slot1"}, {bus.Out_Inst1_en, bus.Out_Inst1, bus.Out_PC1}, e1);
        chk({tag, ".slot2"}, {bus.Out_Inst2_en, bus.Out_Inst2, bus.Out_PC2}, e2);
    endtask

    // Model state change at a clock edge.
    task automatic model_edge();
        bit rdy;
        bit byp;
        int npop;
        if (bus.Flush) begin
            mq.delete();
            return;
        end
        rdy  = (DEPTH - mq.size()) >= 2;
        byp  = model_bypass();
        npop = bus.Stall ? 0 : ((mq.size() >= 2) ? 2 : mq.size());
        repeat (npop) void'(mq.pop_front());
        if (rdy && !byp) begin
            if (bus.In_Inst1_en) mq.push_back(ent_t'({bus.In_Inst1, bus.In_PC}));
            if (bus.In_Inst2_en) mq.push_back(ent_t'({bus.In_Inst2, bus.In_PC + 32'd4}));
        end
    endtask

    task automatic cycle(input string tag);
        #1;
        check_model(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic bundle(input logic [31:0] base, input logic [31:0] pc, input bit stall);
        drive(1'b1, base, 1'b1, base + 32'd1, pc, stall, 1'b0);
        cycle("bundle");
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b1;
        idle(1'b0);
        #2;
        chk("reset.count", 65'(bus.Count), 65'd0);
        chk("reset.ready", 65'(bus.In_ready), 65'd1);
        chk("reset.slot1", {bus.Out_Inst1_en, bus.Out_Inst1, bus.Out_PC1}, 65'd0);
        chk("reset.slot2", {bus.Out_Inst2_en, bus.Out_Inst2, bus.Out_PC2}, 65'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single bundle after reset
        drive(1'b1, 32'h11, 1'b1, 32'h22, 32'h400, 1'b0, 1'b0);
        cycle("single.enq");
        idle(1'b0);
        cycle("single.out");
        cycle("single.empty");

        // Compaction
        drive(1'b0, 32'h0, 1'b1, 32'h33, 32'h500, 1'b1, 1'b0);
        cycle("compact.a");
        drive(1'b1, 32'h44, 1'b0, 32'h0, 32'h600, 1'b1, 1'b0);
        cycle("compact.b");
        idle(1'b1);
        #1;
        chk("compact.slot1", {bus.Out_Inst1_en, bus.Out_Inst1, bus.Out_PC1}, {1'b1, 32'h33, 32'h504});
        chk("compact.slot2", {bus.Out_Inst2_en, bus.Out_Inst2, bus.Out_PC2}, {1'b1, 32'h44, 32'h600});
        idle(1'b0);
        cycle("compact.drain");
        cycle("compact.done");

        // Fill under stall
        drive(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        cycle("fill.flush");
        for (int k = 0; k < 3; k++) bundle(32'h100 + 32'(k * 16), 32'h1000 + 32'(k * 8), 1'b1);
        chk("fill.count6", 65'(bus.Count), 65'd6);
        bundle(32'h130, 32'h1018, 1'b1);
        chk("fill.count8", 65'(bus.Count), 65'd8);
        chk("fill.notready", 65'(bus.In_ready), 65'd0);
        bundle(32'h140, 32'h1020, 1'b1);
        chk("fill.ignored", 65'(bus.Count), 65'd8);
        idle(1'b0);
        for (int k = 0; k < 5; k++) cycle("fill.drain");

        // Wrap-around: bring head and tail to index 7, then a pair spanning 7 and 0
        drive(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        cycle("wrap.flush");
        for (int k = 0; k < 3; k++) bundle(32'h200 + 32'(k * 16), 32'h2000 + 32'(k * 8), 1'b1);
        drive(1'b1, 32'h230, 1'b0, 32'd0, 32'h2018, 1'b1, 1'b0);
        cycle("wrap.single");
        idle(1'b0);
        for (int k = 0; k < 4; k++) cycle("wrap.drain");
        drive(1'b1, 32'hA7, 1'b1, 32'hA0, 32'h3000, 1'b1, 1'b0);
        cycle("wrap.pair");
        idle(1'b0);
        #1;
        chk("wrap.slot1", {bus.Out_Inst1_en, bus.Out_Inst1, bus.Out_PC1}, {1'b1, 32'hA7, 32'h3000});
        chk("wrap.slot2", {bus.Out_Inst2_en, bus.Out_Inst2, bus.Out_PC2}, {1'b1, 32'hA0, 32'h3004});
        cycle("wrap.deq");
        cycle("wrap.empty");

        // Flush colliding with enqueue and dequeue
        for (int k = 0; k < 2; k++) bundle(32'h300 + 32'(k * 16), 32'h4000 + 32'(k * 8), 1'b1);
        drive(1'b1, 32'h320, 1'b0, 32'd0, 32'h4010, 1'b1, 1'b0);
        cycle("flush.fill");
        chk("flush.count5", 65'(bus.Count), 65'd5);
        drive(1'b1, 32'h330, 1'b1, 32'h331, 32'h4020, 1'b0, 1'b1);
        cycle("flush.hit");
        idle(1'b0);
        #1;
        chk("flush.count", 65'(bus.Count), 65'd0);
        chk("flush.ens", {63'd0, bus.Out_Inst1_en, bus.Out_Inst2_en}, 65'd0);
        chk("flush.ready", 65'(bus.In_ready), 65'd1);

        // Asynchronous reset mid-stream
        bundle(32'h400, 32'h5000, 1'b1);
        drive(1'b1, 32'h410, 1'b0, 32'd0, 32'h5008, 1'b1, 1'b0);
        cycle("areset.fill");
        idle(1'b1);
        #1;
        chk("areset.count3", 65'(bus.Count), 65'd3);
        rst = 1'b1;
        #1;
        chk("areset.count", 65'(bus.Count), 65'd0);
        chk("areset.ens", {63'd0, bus.Out_Inst1_en, bus.Out_Inst2_en}, 65'd0);
        mq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1'b0);
        cycle("areset.after");

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
                  $urandom & 32'hFFFF_FFFC, $urandom_range(0, 9) < 4, $urandom_range(0, 31) == 0);
            cycle("rand");
        end
        idle(1'b0);
        for (int k = 0; k < 6; k++) cycle("final");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
